i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  I2C target (responder) that pairs with the team's I2C master controller on the same SCL/SDA bus.
//  Decodes the 7-bit device address, then a 1- or 2-byte register address.
//  Provides write, current/random read via repeated START, and burst transfers with address auto-increment.
//  Exposes a simple synchronous register-file port; used as a bus-level sensor model and as an on-chip config target.
// PARAMETERS
//  DEVICE_ADDR  7'b1010_000  7-bit address this target answers to
//  ADDR_BYTES   2            register address bytes after device address: 1 or 2 (1 => reg_addr[15:8]=0)
// PORTS
//  sys_clk      in     1   system clock, >= 16x SCL frequency (50 MHz nominal)
//  sys_rst_n    in     1   asynchronous active-low reset
//  i2c_scl      in     1   bus SCL (target never stretches)
//  i2c_sda      inout  1   bus SDA, open-drain: driven 1'b0 or 1'bz only, never 1'b1
//  reg_addr     out    16  current register address
//  reg_wr_data  out    8   write data, valid while reg_wr_en=1
//  reg_wr_en    out    1   one-sys_clk write strobe
//  reg_rd_data  in     8   read data for reg_addr, must be valid <=2 sys_clk after reg_addr changes
//  busy         out    1   high from address-matched START until STOP/mismatch
// BEHAVIOUR
//  Reset: sda released (z), reg_addr=0, reg_wr_data=0, reg_wr_en=0, busy=0, state=IDLE.
//  Mid-transfer reset: outputs go to their reset values immediately, the shift register is cleared, and the bus is released at once.
//  Sampling:
//   - SCL and SDA each pass through a 2-FF synchronizer; edge detection runs on the synced values.
//   - All timing below refers to the synced edges.
//  Conditions:
//   - START = SDA fall while SCL=1. STOP = SDA rise while SCL=1.
//   - START in any state, including repeated START, -> DEV_ADDR with bit count 0.
//   - STOP in any state -> IDLE, busy=0, sda released.
//  Bit timing:
//   - Incoming data is shifted MSB first on SCL rise.
//   - The target changes SDA only on SCL fall.
//   - ACK: after the fall ending bit 8, drive 0 until the fall ending bit 9.
//  States:
//   - IDLE: wait for START.
//   - DEV_ADDR: 8 bits. If [7:1]==DEVICE_ADDR, ACK and set busy=1.
//     R/W=0 -> ADDR_H (ADDR_L if ADDR_BYTES=1). R/W=1 -> RD_DATA.
//     On mismatch -> IGNORE with no ACK.
//   - ADDR_H / ADDR_L: 8 bits each, ACK each byte.
//     reg_addr is loaded after the ADDR_L byte completes; ADDR_L -> WR_DATA.
//   - WR_DATA: on the 8th SCL rise, reg_wr_data=byte and reg_wr_en pulses exactly 1 cycle (3 sys_clk after the raw edge).
//     ACK the byte. reg_addr+1 on the cycle after reg_wr_en. Stay in WR_DATA for burst.
//   - RD_DATA: load the shift register from reg_rd_data on the SCL fall that begins the byte.
//     Drive 0 for data bits that are 0; release (z) for bits that are 1.
//     Release after bit 8 and sample the master ACK/NACK on the 9th SCL rise:
//     ACK (0) -> reg_addr+1, next byte. NACK (1) -> IGNORE.
//   - IGNORE: sda released; leave only on START or STOP.
//  Address arithmetic: 16-bit wrap, 16'hFFFF+1=16'h0000. With ADDR_BYTES=1 the address wraps at 8 bits: 16'h00FF+1=16'h0000.
//  Current-address read: START+DEV(R) without preceding address bytes reads the current reg_addr.
//  Partial byte: a START or STOP mid-byte aborts the byte. No reg_wr_en is issued, and reg_addr is unchanged.
//  Simultaneous events: STOP/START take priority over bit processing in the same cycle.
//  Unknown or unused state -> IDLE.
// TESTING
//  1. Write, 2-byte address: START, A0, 00, 3C, 5A, STOP. ACK on all 4 bytes; one reg_wr_en with reg_addr=003C, reg_wr_data=5A; reg_addr ends at 003D.
//  2. Random read: prior write leaves 003C. START, A0, 00, 3C, repeated START, A1, read, NACK, STOP. SDA carries the model's mem[003C]=5A; busy=0 after STOP.
//  3. Burst: write 11,22,33 at FFFE. Strobes go to FFFE, FFFF, 0000. Burst read from FFFE with ACK,ACK,NACK returns 11,22,33.
//  4. Address mismatch: START, A2, then 3 bytes. SDA is never driven low and there is no reg_wr_en. Next START, A0 is ACKed.
//  5. Abort: STOP after 4 bits of WR_DATA gives no reg_wr_en and reg_addr unchanged. Separately, sys_rst_n=0 while driving a read 0 releases SDA at once and all outputs return to reset values.
//  6. Loopback: team I2C master (wr_en, addr_num=1, byte_addr=1234, wr_data=A5), then a read of the same address. Master i2c_end asserts for both; master rd_data=A5.

Source files
------------

// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// i2c_slave_regs: I2C target with 7-bit device address, 1- or 2-byte register
// address, writes, current/random reads and auto-incrementing bursts, bridged
// onto a simple synchronous register-file port.
//
// Ports
//   sys_clk      system clock (>= 16x SCL)
//   sys_rst_n    asynchronous active-low reset
//   i2c_scl      bus SCL (never stretched)
//   i2c_sda      bus SDA, open-drain (0 or z only)
//   reg_addr     current register address
//   reg_wr_data  write data, valid while reg_wr_en is high
//   reg_wr_en    one-cycle write strobe
//   reg_rd_data  read data for reg_addr (valid <= 2 cycles after reg_addr changes)
//   busy         high from address-matched START until STOP or mismatch
module i2c_slave_regs #(
    parameter logic [6:0]  DEVICE_ADDR = 7'b1010_000,
    parameter int unsigned ADDR_BYTES  = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i2c_scl,
    inout  wire logic   i2c_sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wr_data,
    output logic        reg_wr_en,
    input  logic [7:0]  reg_rd_data,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DEV    = 3'd1;
    localparam logic [2:0] ST_ADDR_H = 3'd2;
    localparam logic [2:0] ST_ADDR_L = 3'd3;
    localparam logic [2:0] ST_WR     = 3'd4;
    localparam logic [2:0] ST_RD     = 3'd5;
    localparam logic [2:0] ST_IGN    = 3'd6;

    localparam int unsigned CNT_W = 4;

    // Synchronizers plus one extra stage for edge detection.
    logic scl_m, scl_s, scl_q;
    logic sda_m, sda_s, sda_q;

    // Sequential state.
    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       addr_hi_q, addr_hi_d;
    logic             inc_pend_q, inc_pend_d;
    logic             sda_low_q, sda_low_d;
    logic [15:0]      reg_addr_d;
    logic [7:0]       wr_data_d;
    logic             wr_en_d;
    logic             busy_d;

    logic scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0]  rx_byte_c;
    logic [15:0] addr_inc_c;

    // Open-drain output: only ever pull low or release.
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    // Bus synchronizers; reset to the idle-high level so reset causes no false edges.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_q <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_m <= i2c_scl;
            scl_s <= scl_m;
            scl_q <= scl_s;
            sda_m <= i2c_sda;
            sda_s <= sda_m;
            sda_q <= sda_s;
        end
    end

    assign scl_rise_c = scl_s & ~scl_q;
    assign scl_fall_c = ~scl_s & scl_q;
    assign start_c    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_c     = scl_s & scl_q & ~sda_q & sda_s;
    assign rx_byte_c  = {shift_q[6:0], sda_s};

    // Single-byte addressing wraps inside the low byte.
    assign addr_inc_c = (ADDR_BYTES == 1) ? {8'h00, 8'(reg_addr[7:0] + 8'd1)}
                                          : 16'(reg_addr + 16'd1);

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_hi_q   <= '0;
            inc_pend_q  <= 1'b0;
            sda_low_q   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_hi_q   <= addr_hi_d;
            inc_pend_q  <= inc_pend_d;
            sda_low_q   <= sda_low_d;
            reg_addr    <= reg_addr_d;
            reg_wr_data <= wr_data_d;
            reg_wr_en   <= wr_en_d;
            busy        <= busy_d;
        end
    end

    // Next-state and next-output logic.
    // bit_cnt: 0..7 data bits seen, 8 = byte done (ACK slot pending), 9 = ACK clocked.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_hi_d  = addr_hi_q;
        inc_pend_d = 1'b0;
        sda_low_d  = sda_low_q;
        reg_addr_d = reg_addr;
        wr_data_d  = reg_wr_data;
        wr_en_d    = 1'b0;
        busy_d     = busy;

        // Post-write increment lands the cycle after the strobe.
        if (inc_pend_q) begin
            reg_addr_d = addr_inc_c;
        end

        if (stop_c) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_c) begin
            state_d   = ST_DEV;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGN: begin
                    sda_low_d = 1'b0;
                end

                ST_DEV, ST_ADDR_H, ST_ADDR_L, ST_WR: begin
                    if (scl_rise_c) begin
                        if (bit_cnt_q < CNT_W'(8)) begin
                            shift_d   = rx_byte_c;
                            bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
                            if (bit_cnt_q == CNT_W'(7)) begin
                                if (state_q == ST_DEV) begin
                                    if (rx_byte_c[7:1] == DEVICE_ADDR) begin
                                        busy_d = 1'b1;
                                    end else begin
                                        state_d   = ST_IGN;
                                        bit_cnt_d = '0;
                                        busy_d    = 1'b0;
                                    end
                                end else if (state_q == ST_ADDR_H) begin
                                    addr_hi_d = rx_byte_c;
                                end else if (state_q == ST_ADDR_L) begin
                                    reg_addr_d = (ADDR_BYTES == 1) ? {8'h00, rx_byte_c}
                                                                   : {addr_hi_q, rx_byte_c};
                                end else begin
                                    wr_data_d  = rx_byte_c;
                                    wr_en_d    = 1'b1;
                                    inc_pend_d = 1'b1;
                                end
                            end
                        end else if (bit_cnt_q == CNT_W'(8)) begin
                            bit_cnt_d = CNT_W'(9);
                        end
                    end else if (scl_fall_c) begin
                        if (bit_cnt_q == CNT_W'(8)) begin
                            sda_low_d = 1'b1;
                        end else if (bit_cnt_q == CNT_W'(9)) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ST_DEV) begin
                                if (shift_q[0]) begin
                                    // Read: this fall begins the first data byte.
                                    state_d   = ST_RD;
                                    shift_d   = reg_rd_data;
                                    sda_low_d = ~reg_rd_data[7];
                                end else begin
                                    state_d = (ADDR_BYTES == 1) ? ST_ADDR_L : ST_ADDR_H;
                                end
                            end else if (state_q == ST_ADDR_H) begin
                                state_d = ST_ADDR_L;
                            end else begin
                                state_d = ST_WR;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (scl_rise_c) begin
                        if (bit_cnt_q < CNT_W'(8)) begin
                            bit_cnt_d = CNT_W'(bit_cnt_q + CNT_W'(1));
                        end else if (bit_cnt_q == CNT_W'(8)) begin
                            if (sda_s) begin
                                state_d   = ST_IGN;
                                bit_cnt_d = '0;
                            end else begin
                                reg_addr_d = addr_inc_c;
                                bit_cnt_d  = CNT_W'(9);
                            end
                        end
                    end else if (scl_fall_c) begin
                        if (bit_cnt_q == CNT_W'(9)) begin
                            shift_d   = reg_rd_data;
                            sda_low_d = ~reg_rd_data[7];
                            bit_cnt_d = '0;
                        end else if (bit_cnt_q == CNT_W'(8)) begin
                            sda_low_d = 1'b0;
                        end else if (bit_cnt_q != '0) begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    sda_low_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
// Scoreboard bench for i2c_slave_regs: bit-banged bus master, external
// register file, and a transaction-level reference memory.
module tb_i2c_slave_regs;

    localparam int Q = 8;  // sys_clk cycles per quarter SCL period

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda_bus;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wr_data;
    logic        reg_wr_en;
    logic [7:0]  reg_rd_data;
    logic        busy;

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #10 sys_clk = ~sys_clk;

    i2c_slave_regs dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .i2c_scl    (m_scl),
        .i2c_sda    (sda_bus),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_data(reg_rd_data),
        .busy       (busy)
    );

    // Register file attached to the DUT port, and the reference memory.
    logic [7:0] dev_mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    assign reg_rd_data = dev_mem[reg_addr];
    always @(posedge sys_clk) if (reg_wr_en) dev_mem[reg_addr] <= reg_wr_data;

    int   n_checks = 0;
    int   n_pass = 0;
    wr_t  exp_wr[$];
    logic exp_ack[$], obs_ack[$];
    logic [7:0] exp_rd[$], obs_rd[$];
    logic [15:0] exp_addr;
    bit   watch = 1'b0;
    int   drive_cnt = 0;

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    // Monitor: compares DUT-presented outputs against queued expectations.
    initial begin
        wr_t        e;
        logic       a;
        logic [7:0] rb;
        bit         prev_wr = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (reg_wr_en) begin
                if (exp_wr.size() == 0) check("unexpected_wr_en", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", int'(reg_addr), int'(e.addr));
                    check("wr_data", int'(reg_wr_data), int'(e.data));
                end
                check("wr_en_single_cycle", int'(prev_wr), 0);
            end
            prev_wr = reg_wr_en;
            while (obs_ack.size() > 0) begin
                a = obs_ack.pop_front();
                if (exp_ack.size() == 0) check("unexpected_ack", 1, 0);
                else check("ack_bit", int'(a), int'(exp_ack.pop_front()));
            end
            while (obs_rd.size() > 0) begin
                rb = obs_rd.pop_front();
                if (exp_rd.size() == 0) check("unexpected_rd", 1, 0);
                else check("rd_byte", int'(rb), int'(exp_rd.pop_front()));
            end
            if (watch && sda_bus === 1'b0 && !m_low) drive_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic qwait();
        repeat (Q) @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        repeat (8) @(posedge sys_clk);
        #1;
    endtask

    task automatic i2c_start();
        m_low = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_low = 1'b1; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_low = 1'b0; qwait(); qwait();
    endtask

    task automatic send_bit(input logic b);
        m_low = !b; qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        b = sda_bus;  qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic want_ack);
        logic a;
        exp_ack.push_back(want_ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(a);
        obs_ack.push_back(a);
    endtask

    task automatic recv_byte(input logic [7:0] want, input bit ack);
        logic [7:0] b;
        logic       x;
        exp_rd.push_back(want);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(x);
            b[i] = x;
        end
        obs_rd.push_back(b);
        send_bit(!ack);
    endtask

    task automatic post_checks(input string tag);
        settle();
        check({tag, "_reg_addr"}, int'(reg_addr), int'(exp_addr));
        check({tag, "_busy_after_stop"}, int'(busy), 0);
        check({tag, "_wr_queue_drained"}, exp_wr.size(), 0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] d[$]);
        logic [15:0] a = addr;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(addr[15:8], 1'b0);
        send_byte(addr[7:0], 1'b0);
        foreach (d[i]) begin
            exp_wr.push_back('{addr: a, data: d[i]});
            ref_mem[a] = d[i];
            send_byte(d[i], 1'b0);
            a = 16'(a + 16'd1);
        end
        check("busy_during_write", int'(busy), 1);
        i2c_stop();
        exp_addr = a;
        post_checks("write");
    endtask

    // random=1 sets the address first; random=0 reads from the current address.
    task automatic do_read(input logic [15:0] addr, input int n, input bit random);
        logic [15:0] a = random ? addr : exp_addr;
        i2c_start();
        if (random) begin
            send_byte(8'hA0, 1'b0);
            send_byte(addr[15:8], 1'b0);
            send_byte(addr[7:0], 1'b0);
            i2c_start();
        end
        send_byte(8'hA1, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(ref_mem[a], i != n - 1);
            if (i != n - 1) a = 16'(a + 16'd1);
        end
        i2c_stop();
        exp_addr = a;
        post_checks("read");
    endtask

    initial begin
        logic [7:0]  d[$];
        logic [15:0] ra;
        int          n;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        exp_addr = 16'h0000;
        repeat (5) @(posedge sys_clk);
        #1;
        check("rst_reg_addr", int'(reg_addr), 0);
        check("rst_wr_data", int'(reg_wr_data), 0);
        check("rst_wr_en", int'(reg_wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sda_released", int'(sda_bus === 1'b1), 1);
        sys_rst_n = 1'b1;
        settle();

        // Single write, then random read of the same address.
        d = '{8'h5A};
        do_write(16'h003C, d);
        do_read(16'h003C, 1, 1'b1);

        // Burst across the 16-bit wrap.
        d = '{8'h11, 8'h22, 8'h33};
        do_write(16'hFFFE, d);
        do_read(16'hFFFE, 3, 1'b1);

        // Address mismatch: no ACK, no drive, no strobe; then a matched write.
        watch = 1'b1;
        drive_cnt = 0;
        i2c_start();
        send_byte(8'hA2, 1'b1);
        check("busy_after_mismatch", int'(busy), 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        watch = 1'b0;
        check("mismatch_no_drive", drive_cnt, 0);
        d = '{8'hC3};
        do_write(16'h0200, d);

        // Partial data byte aborted by STOP.
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h50, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        exp_addr = 16'h0050;
        post_checks("abort");

        // Reset while the target drives a 0 data bit.
        d = '{8'h3C};
        do_write(16'h0100, d);
        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        i2c_start();
        send_byte(8'hA1, 1'b0);
        check("rd_bit7_driven_low", int'(sda_bus === 1'b0 && !m_low), 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_sda_released", int'(sda_bus === 1'b1), 1);
        check("midrst_reg_addr", int'(reg_addr), 0);
        check("midrst_wr_data", int'(reg_wr_data), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (4) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        exp_addr = 16'h0000;
        i2c_stop();
        post_checks("after_reset");

        // Loopback-style write then read at 1234.
        d = '{8'hA5};
        do_write(16'h1234, d);
        do_read(16'h1234, 1, 1'b1);

        // Randomized write/read-back rounds, with a current-address read.
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom);
            n = int'($urandom_range(1, 3));
            d = {};
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            do_write(ra, d);
            do_read(ra, n, 1'b1);
            do_read(16'h0000, 1, 1'b0);
        end

        settle();
        check("ack_queue_drained", exp_ack.size() + obs_ack.size(), 0);
        check("rd_queue_drained", exp_rd.size() + obs_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
